rf_dump: RTL and testbench

Debug read-out engine for the SISC register file. On a start command it walks a range of register addresses through one register-file read port, absorbs the port's one-cycle registered read latency, and streams each register value out over a valid/ready handshake. It sits beside the datapath and drives the register file's port-A read address (`read_rega`) while the core is halted. It consumes that port's registered output (`rsa`).

---
 rtl/rf_dump.sv | 129 ++++++++++++
 tb/tb_rf_dump.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_dump.sv
// Debug read-out engine: walks a register-file address range through one read port and
// streams each value out over a valid/ready handshake.
module rf_dump #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_reg,
   input  logic [ADDR_W-1:0] end_reg,
   input  logic              abort,
   output logic [ADDR_W-1:0] rd_reg,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_idx,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {StIdle, StRead, StCapt, StSend} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cur_q, cur_d;
   logic [ADDR_W-1:0]   last_q, last_d;
   logic [ADDR_W-1:0]   rd_reg_q, rd_reg_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic [ADDR_W-1:0]   out_idx_q, out_idx_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [ADDR_W-1:0]   cur_inc;

   // Address arithmetic wraps naturally at the register-file size.
   assign cur_inc = cur_q + ADDR_W'(1);

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      last_d      = last_q;
      rd_reg_d    = rd_reg_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      busy_d      = busy_q;
      done_d      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start && !abort) begin
               cur_d    = start_reg;
               last_d   = end_reg;
               rd_reg_d = start_reg;
               busy_d   = 1'b1;
               state_d  = StRead;
            end
         end
         StRead: begin
            // Register file latches rd_data at this edge.
            state_d = StCapt;
         end
         StCapt: begin
            out_data_d  = rd_data;
            out_idx_d   = cur_q;
            out_valid_d = 1'b1;
            state_d     = StSend;
         end
         StSend: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               if (cur_q == last_q) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = StIdle;
               end else begin
                  cur_d    = cur_inc;
                  rd_reg_d = cur_inc;
                  state_d  = StRead;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Abort wins over any handshake; a pending word is dropped without a done pulse.
      if (abort && (state_q != StIdle)) begin
         state_d     = StIdle;
         out_valid_d = 1'b0;
         busy_d      = 1'b0;
         done_d      = 1'b0;
         cur_d       = cur_q;
         rd_reg_d    = rd_reg_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cur_q       <= '0;
         last_q      <= '0;
         rd_reg_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         last_q      <= last_d;
         rd_reg_q    <= rd_reg_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign rd_reg    = rd_reg_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_rf_dump.sv
// Directed bench for rf_dump with a registered-read register-file model on the read port.
module tb_rf_dump;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  start_reg;
   logic [3:0]  end_reg;
   logic        abort;
   logic [3:0]  rd_reg;
   logic [31:0] rd_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_idx;
   logic        busy;
   logic        done;

   logic [31:0] rf [16];
   int          n_checks = 0;
   int          n_pass = 0;
   int          done_cnt = 0;

   always #5 clk = ~clk;

   rf_dump #(.DATA_W(32), .ADDR_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .start_reg (start_reg),
      .end_reg   (end_reg),
      .abort     (abort),
      .rd_reg    (rd_reg),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .busy      (busy),
      .done      (done)
   );

   // Register file port A: registered read, R0 hard-wired to zero.
   always @(posedge clk) rd_data <= (rd_reg == 4'd0) ? 32'd0 : rf[rd_reg];

   always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic [31:0] exp_data(input int i);
      return (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [3:0] s, input logic [3:0] e);
      start = 1'b1;
      start_reg = s;
      end_reg = e;
      tick();
      start = 1'b0;
      check("start_busy", 32'(busy), 32'd1);
      check("start_rd_reg", 32'(rd_reg), 32'(s));
   endtask

   // Waits (bounded) for out_valid; lat is the number of edges from the call to its rise.
   task automatic expect_word(input logic [3:0] idx, input logic [31:0] data, input int lat);
      int cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!out_valid && cyc < 12);
      check("word_valid", 32'(out_valid), 32'd1);
      check("word_lat", 32'(cyc), 32'(lat));
      check("word_idx", 32'(out_idx), 32'(idx));
      check("word_data", out_data, data);
   endtask

   // Last word is visible and out_ready is high: handshake edge then done pulse.
   task automatic finish_dump();
      tick();
      check("fin_done", 32'(done), 32'd1);
      check("fin_busy", 32'(busy), 32'd0);
      check("fin_valid", 32'(out_valid), 32'd0);
   endtask

   initial begin
      int d0;
      rst = 1'b1;
      start = 1'b0;
      start_reg = '0;
      end_reg = '0;
      abort = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) rf[i] = exp_data(i);
      #3;
      check("rst_rd_reg", 32'(rd_reg), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", out_data, 32'd0);
      check("rst_idx", 32'(out_idx), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Full dump 0..15, ready held high.
      out_ready = 1'b1;
      d0 = done_cnt;
      do_start(4'd0, 4'd15);
      for (int i = 0; i < 16; i++) expect_word(4'(i), exp_data(i), (i == 0) ? 2 : 3);
      finish_dump();
      tick();
      check("full_done_low", 32'(done), 32'd0);
      check("full_done_cnt", 32'(done_cnt - d0), 32'd1);

      // Wrapping range 14..1.
      do_start(4'd14, 4'd1);
      expect_word(4'd14, exp_data(14), 2);
      expect_word(4'd15, exp_data(15), 3);
      expect_word(4'd0, exp_data(0), 3);
      expect_word(4'd1, exp_data(1), 3);
      finish_dump();
      tick();

      // Single register with back-pressure.
      rf[3] = 32'hDEAD_BEEF;
      out_ready = 1'b0;
      d0 = done_cnt;
      do_start(4'd3, 4'd3);
      expect_word(4'd3, 32'hDEAD_BEEF, 2);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_data", out_data, 32'hDEAD_BEEF);
         check("hold_idx", 32'(out_idx), 32'd3);
      end
      out_ready = 1'b1;
      finish_dump();
      tick();
      check("hold_done_low", 32'(done), 32'd0);
      check("hold_done_cnt", 32'(done_cnt - d0), 32'd1);
      rf[3] = exp_data(3);

      // Abort while R5 is pending in SEND (ready high: abort beats the handshake).
      d0 = done_cnt;
      do_start(4'd0, 4'd15);
      for (int i = 0; i < 6; i++) expect_word(4'(i), exp_data(i), (i == 0) ? 2 : 3);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_valid", 32'(out_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      for (int i = 0; i < 4; i++) tick();
      check("abort_idle_busy", 32'(busy), 32'd0);
      check("abort_done_cnt", 32'(done_cnt - d0), 32'd0);
      do_start(4'd2, 4'd4);
      expect_word(4'd2, exp_data(2), 2);
      expect_word(4'd3, exp_data(3), 3);
      expect_word(4'd4, exp_data(4), 3);
      finish_dump();
      tick();

      // Start mid-dump is ignored; start right after done begins a new dump.
      do_start(4'd6, 4'd9);
      expect_word(4'd6, exp_data(6), 2);
      expect_word(4'd7, exp_data(7), 3);
      start = 1'b1;
      start_reg = 4'd0;
      end_reg = 4'd0;
      tick();
      start = 1'b0;
      check("ign_busy", 32'(busy), 32'd1);
      expect_word(4'd8, exp_data(8), 2);
      expect_word(4'd9, exp_data(9), 3);
      finish_dump();
      do_start(4'd9, 4'd10);
      check("b2b_done_low", 32'(done), 32'd0);
      expect_word(4'd9, exp_data(9), 2);
      expect_word(4'd10, exp_data(10), 3);
      finish_dump();
      tick();

      // Asynchronous reset mid-dump.
      d0 = done_cnt;
      do_start(4'd4, 4'd12);
      expect_word(4'd4, exp_data(4), 2);
      expect_word(4'd5, exp_data(5), 3);
      #2;
      rst = 1'b1;
      #1;
      check("arst_rd_reg", 32'(rd_reg), 32'd0);
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_data", out_data, 32'd0);
      check("arst_idx", 32'(out_idx), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      #2;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_rst_busy", 32'(busy), 32'd0);
         check("post_rst_valid", 32'(out_valid), 32'd0);
      end
      check("post_rst_done_cnt", 32'(done_cnt - d0), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
